// File: rtl/gelato_register_bank_arbiter.sv
// gelato_register_bank_arbiter: banked register file with a per-batch bank
// arbiter. One batched operand request in, one response out (IDLE -> ARB ->
// READ -> RESP). Each bank serves at most one read per batch. The single
// writeback port always beats a read on the same bank.

// One single-ported register bank: synchronous write, synchronous read.
module gelato_register_bank_arbiter_bank #(
  parameter int ROW_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [DATA_W-1:0] rd_data
);
  localparam int ROWS = 1 << ROW_W;

  logic [ROWS-1:0][DATA_W-1:0] mem;

  // Storage and read register; both freeze while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem     <= '0;
      rd_data <= '0;
    end else if (rdy) begin
      if (wr_en) mem[wr_row] <= wr_data;
      if (rd_en) rd_data <= mem[rd_row];
    end
  end
endmodule

module gelato_register_bank_arbiter #(
  parameter int COLLECTOR_SIZE = 4,
  parameter int SLOT_NUM       = 4,
  parameter int BANK_NUM       = 4,
  parameter int REG_ADDR_W     = 5,
  parameter int DATA_W         = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   rdy,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [COLLECTOR_SIZE-1:0]              req_entry_valid,
  input  logic [COLLECTOR_SIZE*2-1:0]            req_collector_num,
  input  logic [COLLECTOR_SIZE*SLOT_NUM-1:0]     req_reg_valid,
  input  logic [COLLECTOR_SIZE*SLOT_NUM*REG_ADDR_W-1:0] req_reg_num,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [BANK_NUM-1:0]                    rsp_data_valid,
  output logic [BANK_NUM*2-1:0]                  rsp_collector_index,
  output logic [BANK_NUM*2-1:0]                  rsp_reg_index,
  output logic [BANK_NUM*DATA_W-1:0]             rsp_data,
  input  logic                                   wb_valid,
  input  logic [REG_ADDR_W-1:0]                  wb_reg,
  input  logic [DATA_W-1:0]                      wb_data
);
  localparam int BANK_W = $clog2(BANK_NUM);
  localparam int ROW_W  = REG_ADDR_W - BANK_W;
  localparam int OPS    = COLLECTOR_SIZE * SLOT_NUM;

  typedef enum logic [1:0] {IDLE, ARB, READ, RESP} state_t;

  typedef struct packed {
    logic [COLLECTOR_SIZE-1:0]             ent_vld;
    logic [COLLECTOR_SIZE-1:0][1:0]        coll;
    logic [OPS-1:0]                        reg_vld;
    logic [OPS-1:0][REG_ADDR_W-1:0]        reg_num;
  } batch_t;

  state_t state, state_nxt;
  batch_t batch_q;

  logic [OPS-1:0]                   pend;
  logic [BANK_NUM-1:0]              gnt;
  logic [BANK_NUM-1:0][1:0]         gnt_coll;
  logic [BANK_NUM-1:0][1:0]         gnt_slot;
  logic [BANK_NUM-1:0][ROW_W-1:0]   gnt_row;

  logic [BANK_NUM-1:0]              gnt_q;
  logic [BANK_NUM-1:0][1:0]         gnt_coll_q;
  logic [BANK_NUM-1:0][1:0]         gnt_slot_q;
  logic [BANK_NUM-1:0][DATA_W-1:0]  bank_rd;

  logic [BANK_NUM-1:0]              rsp_dv_q;
  logic [BANK_NUM-1:0][1:0]         rsp_coll_q;
  logic [BANK_NUM-1:0][1:0]         rsp_slot_q;
  logic [BANK_NUM-1:0][DATA_W-1:0]  rsp_data_q;

  logic [BANK_W-1:0] wb_bank;
  logic [ROW_W-1:0]  wb_row;
  logic              wb_en;

  // Register 0 is hard-wired: its write is dropped, and since storage resets
  // to zero and is never written there, it always reads back as zero.
  assign wb_bank = wb_reg[BANK_W-1:0];
  assign wb_row  = wb_reg[REG_ADDR_W-1:BANK_W];
  assign wb_en   = rdy && wb_valid && (wb_reg != '0);

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // State register; a reset aborts any batch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  // Next-state: ARB and READ are single-cycle, RESP waits for the collector.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ARB;
      ARB:     state_nxt = READ;
      READ:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the whole batch on acceptance; it is only consulted in ARB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   batch_q <= '0;
    else if (rdy && state == IDLE && req_valid) begin
      batch_q.ent_vld <= req_entry_valid;
      batch_q.coll    <= req_collector_num;
      batch_q.reg_vld <= req_reg_valid;
      batch_q.reg_num <= req_reg_num;
    end
  end

  // Operand qualification: slot 0 is never a register read.
  always_comb begin
    pend = '0;
    for (int e = 0; e < COLLECTOR_SIZE; e++)
      for (int s = 1; s < SLOT_NUM; s++)
        pend[e*SLOT_NUM+s] = batch_q.ent_vld[e] && batch_q.reg_vld[e*SLOT_NUM+s];
  end

  // Slot-0 fields are latched with the batch but have no meaning here.
  logic [REG_ADDR_W:0] slot0_fold;
  logic                unused_slot0;
  always_comb begin
    slot0_fold = '0;
    for (int e = 0; e < COLLECTOR_SIZE; e++)
      slot0_fold = slot0_fold ^ {batch_q.reg_vld[e*SLOT_NUM], batch_q.reg_num[e*SLOT_NUM]};
  end
  assign unused_slot0 = ^slot0_fold;

  // Per-bank fixed priority: lowest e*SLOT_NUM+s wins; a writeback to the
  // bank in the same cycle kills the grant.
  always_comb begin
    gnt      = '0;
    gnt_coll = '0;
    gnt_slot = '0;
    gnt_row  = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      for (int e = 0; e < COLLECTOR_SIZE; e++) begin
        for (int s = 0; s < SLOT_NUM; s++) begin
          if (!gnt[b] && pend[e*SLOT_NUM+s] &&
              batch_q.reg_num[e*SLOT_NUM+s][BANK_W-1:0] == BANK_W'(b)) begin
            gnt[b]      = 1'b1;
            gnt_coll[b] = batch_q.coll[e];
            gnt_slot[b] = 2'(s);
            gnt_row[b]  = batch_q.reg_num[e*SLOT_NUM+s][REG_ADDR_W-1:BANK_W];
          end
        end
      end
      if (wb_en && wb_bank == BANK_W'(b)) gnt[b] = 1'b0;
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < BANK_NUM; gb++) begin : g_bank
      gelato_register_bank_arbiter_bank #(
        .ROW_W  (ROW_W),
        .DATA_W (DATA_W)
      ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .wr_en   (wb_en && wb_bank == BANK_W'(gb)),
        .wr_row  (wb_row),
        .wr_data (wb_data),
        .rd_en   (state == ARB && gnt[gb]),
        .rd_row  (gnt_row[gb]),
        .rd_data (bank_rd[gb])
      );
    end
  endgenerate

  // Remember who each bank read is for while the bank data comes back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= '0;
      gnt_coll_q <= '0;
      gnt_slot_q <= '0;
    end else if (rdy && state == ARB) begin
      gnt_q      <= gnt;
      gnt_coll_q <= gnt_coll;
      gnt_slot_q <= gnt_slot;
    end
  end

  // Response register: loaded in READ, held stable through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_dv_q   <= '0;
      rsp_coll_q <= '0;
      rsp_slot_q <= '0;
      rsp_data_q <= '0;
    end else if (rdy && state == READ) begin
      rsp_dv_q <= gnt_q;
      for (int b = 0; b < BANK_NUM; b++) begin
        rsp_coll_q[b] <= gnt_q[b] ? gnt_coll_q[b] : 2'd0;
        rsp_slot_q[b] <= gnt_q[b] ? gnt_slot_q[b] : 2'd0;
        rsp_data_q[b] <= gnt_q[b] ? bank_rd[b]    : '0;
      end
    end
  end

  assign rsp_data_valid      = rsp_dv_q;
  assign rsp_collector_index = rsp_coll_q;
  assign rsp_reg_index       = rsp_slot_q;
  assign rsp_data            = rsp_data_q;
endmodule

// File: tb/tb_gelato_register_bank_arbiter.sv
// Scoreboard bench for gelato_register_bank_arbiter: stimulus pushes the
// hand-computed response, a monitor pops and compares on each handshake.
module tb_gelato_register_bank_arbiter;
  logic         clk = 1'b0;
  logic         rst, rdy;
  logic         req_valid, req_ready;
  logic [3:0]   req_entry_valid;
  logic [7:0]   req_collector_num;
  logic [15:0]  req_reg_valid;
  logic [79:0]  req_reg_num;
  logic         rsp_valid, rsp_ready;
  logic [3:0]   rsp_data_valid;
  logic [7:0]   rsp_collector_index;
  logic [7:0]   rsp_reg_index;
  logic [127:0] rsp_data;
  logic         wb_valid;
  logic [4:0]   wb_reg;
  logic [31:0]  wb_data;

  always #5 clk = ~clk;

  gelato_register_bank_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_entry_valid(req_entry_valid), .req_collector_num(req_collector_num),
    .req_reg_valid(req_reg_valid), .req_reg_num(req_reg_num),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_valid(rsp_data_valid), .rsp_collector_index(rsp_collector_index),
    .rsp_reg_index(rsp_reg_index), .rsp_data(rsp_data),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  typedef struct packed {
    logic [3:0]        dv;
    logic [3:0][1:0]   coll;
    logic [3:0][1:0]   slot;
    logic [3:0][31:0]  data;
  } rsp_t;

  rsp_t sbq[$];
  rsp_t ex;
  int   asserts = 0;
  int   fails   = 0;

  logic [3:0]  r_ev;
  logic [7:0]  r_coll;
  logic [15:0] r_rv;
  logic [79:0] r_rn;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr_req();
    r_ev = '0; r_rv = '0; r_rn = '0;
    r_coll = {2'd3, 2'd2, 2'd1, 2'd0};
  endtask

  task automatic add_op(input int e, input int s, input logic [4:0] r);
    r_ev[e] = 1'b1;
    r_rv[e*4+s] = 1'b1;
    r_rn[(e*4+s)*5 +: 5] = r;
  endtask

  task automatic exp_clr();
    ex = '0;
  endtask

  task automatic exp_set(input int b, input logic [1:0] c, input logic [1:0] s, input logic [31:0] d);
    ex.dv[b] = 1'b1; ex.coll[b] = c; ex.slot[b] = s; ex.data[b] = d;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk); wb_valid = 1'b1; wb_reg = r; wb_data = d;
    @(negedge clk); wb_valid = 1'b0;
  endtask

  // Issue one batch and walk it through to the handshake.
  task automatic send(input bit bp, input bit wbarb, input logic [4:0] wr, input logic [31:0] wd);
    int cnt;
    logic [3:0]   s_dv;
    logic [7:0]   s_ci, s_ri;
    logic [127:0] s_d;
    sbq.push_back(ex);
    @(negedge clk);
    req_entry_valid = r_ev; req_collector_num = r_coll;
    req_reg_valid = r_rv; req_reg_num = r_rn;
    req_valid = 1'b1; rsp_ready = !bp;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_drop", {127'd0, req_ready}, 128'd0);
    if (wbarb) begin wb_valid = 1'b1; wb_reg = wr; wb_data = wd; end
    cnt = 1;
    while (!rsp_valid && cnt < 12) begin
      @(negedge clk);
      wb_valid = 1'b0;
      cnt++;
    end
    chk("latency", 128'(cnt), 128'd3);
    if (!rsp_valid) begin
      rsp_ready = 1'b1;
      return;
    end
    if (bp) begin
      s_dv = rsp_data_valid; s_ci = rsp_collector_index; s_ri = rsp_reg_index; s_d = rsp_data;
      repeat (5) begin
        @(negedge clk);
        chk("bp_rsp_valid", {127'd0, rsp_valid}, 128'd1);
        chk("bp_req_ready", {127'd0, req_ready}, 128'd0);
        chk("bp_stable", {rsp_data_valid, rsp_collector_index, rsp_reg_index, s_d ^ rsp_data},
            {s_dv, s_ci, s_ri, 128'd0});
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_idle", {126'd0, rsp_valid, req_ready}, 128'd1);
  endtask

  // Monitor: compares every accepted response against the scoreboard head.
  always @(negedge clk) begin
    #1;
    if (rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        asserts++; fails++;
        $display("FAIL unexpected_rsp: got response, expected none");
      end else begin
        rsp_t e;
        e = sbq.pop_front();
        chk("rsp_data_valid", 128'(rsp_data_valid), 128'(e.dv));
        for (int b = 0; b < 4; b++) begin
          if (e.dv[b]) begin
            chk($sformatf("rsp_coll[%0d]", b), 128'(rsp_collector_index[b*2 +: 2]), 128'(e.coll[b]));
            chk($sformatf("rsp_slot[%0d]", b), 128'(rsp_reg_index[b*2 +: 2]), 128'(e.slot[b]));
            chk($sformatf("rsp_data[%0d]", b), 128'(rsp_data[b*32 +: 32]), 128'(e.data[b]));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_entry_valid = '0; req_collector_num = '0; req_reg_valid = '0; req_reg_num = '0;
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    clr_req(); exp_clr();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {127'd0, req_ready}, 128'd1);
    chk("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    chk("rst_rsp_vectors", {rsp_data_valid, rsp_collector_index, rsp_reg_index}, 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    rst = 1'b0;

    // Basic read after writeback
    wb(5'd9, 32'hDEADBEEF);
    clr_req(); add_op(0, 1, 5'd9);
    exp_clr(); exp_set(1, 2'd0, 2'd1, 32'hDEADBEEF);
    send(0, 0, '0, '0);

    // Bank 0 conflict, then resubmit the loser
    wb(5'd4, 32'h44); wb(5'd8, 32'h88);
    clr_req(); add_op(0, 1, 5'd4); add_op(1, 2, 5'd8);
    exp_clr(); exp_set(0, 2'd0, 2'd1, 32'h44);
    send(0, 0, '0, '0);
    clr_req(); add_op(1, 2, 5'd8);
    exp_clr(); exp_set(0, 2'd1, 2'd2, 32'h88);
    send(0, 0, '0, '0);

    // Full spread: entry 3 loses bank 1 to entry 0
    wb(5'd1, 32'h11); wb(5'd2, 32'h22); wb(5'd3, 32'h33); wb(5'd5, 32'h55);
    clr_req(); add_op(0, 1, 5'd1); add_op(1, 1, 5'd2); add_op(2, 1, 5'd3); add_op(3, 1, 5'd5);
    exp_clr(); exp_set(1, 2'd0, 2'd1, 32'h11); exp_set(2, 2'd1, 2'd1, 32'h22);
    exp_set(3, 2'd2, 2'd1, 32'h33);
    send(0, 0, '0, '0);

    // Writeback to bank 2 during ARB kills the bank 2 read only
    clr_req(); add_op(0, 1, 5'd2); add_op(1, 1, 5'd5);
    exp_clr(); exp_set(1, 2'd1, 2'd1, 32'h55);
    send(0, 1, 5'd6, 32'h66666666);
    clr_req(); add_op(0, 1, 5'd6);
    exp_clr(); exp_set(2, 2'd0, 2'd1, 32'h66666666);
    send(0, 0, '0, '0);

    // Backpressure on the response
    clr_req(); add_op(2, 3, 5'd3);
    exp_clr(); exp_set(3, 2'd2, 2'd3, 32'h33);
    send(1, 0, '0, '0);

    // Empty batch
    clr_req();
    exp_clr();
    send(0, 0, '0, '0);

    // Slot 0 ignored, invalid entry ignored, reg 0 reads zero
    clr_req(); add_op(0, 0, 5'd1); add_op(1, 1, 5'd0);
    r_rv[2*4+1] = 1'b1; r_rn[(2*4+1)*5 +: 5] = 5'd2;
    exp_clr(); exp_set(0, 2'd1, 2'd1, 32'd0);
    send(0, 0, '0, '0);

    // Writeback under stall is not performed
    @(negedge clk); rdy = 1'b0;
    wb(5'd13, 32'h1234);
    @(negedge clk); rdy = 1'b1;
    clr_req(); add_op(0, 1, 5'd13);
    exp_clr(); exp_set(1, 2'd0, 2'd1, 32'd0);
    send(0, 0, '0, '0);

    // Reset in READ aborts the batch and clears storage
    clr_req(); add_op(0, 1, 5'd9);
    @(negedge clk);
    req_entry_valid = r_ev; req_collector_num = r_coll;
    req_reg_valid = r_rv; req_reg_num = r_rn; req_valid = 1'b1;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    chk("midrst_req_ready", {127'd0, req_ready}, 128'd1);
    chk("midrst_rsp_dv", 128'(rsp_data_valid), 128'd0);
    @(negedge clk); rst = 1'b0;
    exp_clr(); exp_set(1, 2'd0, 2'd1, 32'd0);
    send(0, 0, '0, '0);
    wb(5'd7, 32'hCAFEF00D);
    clr_req(); add_op(3, 2, 5'd7);
    exp_clr(); exp_set(3, 2'd3, 2'd2, 32'hCAFEF00D);
    send(0, 0, '0, '0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(sbq.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/gelato_register_bank_arbiter.md
Name: gelato_register_bank_arbiter

Overview:
- Multi-banked register file plus bank arbiter; sits directly downstream of the operand collector.
- Accepts one batched operand-collect request (all collector entries × operand slots), grants at most one read per bank per batch, and returns one response.
- Unserved reads are dropped; the collector re-requests them next batch because their valid flags are still set.
- Also owns the single writeback port from the execution units.

Parameters:
- COLLECTOR_SIZE, 4, collector entries per request
- SLOT_NUM, 4, operand slots per entry; slot 0 is never requested, slots 1..3 = rs1..rs3
- BANK_NUM, 4, single-ported register banks (power of 2)
- REG_ADDR_W, 5, register number width; bank = reg[log2(BANK_NUM)-1:0], row = remaining upper bits
- DATA_W, 32, register data width

Ports:
- clk, input, 1, clock
- rst, input, 1, asynchronous active-high reset
- rdy, input, 1, global stall; when 0 all state holds
- req_valid, input, 1, request batch valid
- req_ready, output, 1, arbiter can accept a batch (high only in IDLE)
- req_entry_valid, input, COLLECTOR_SIZE, entry valid per collector slot
- req_collector_num, input, COLLECTOR_SIZE*2, collector index per entry
- req_reg_valid, input, COLLECTOR_SIZE*SLOT_NUM, operand wanted
- req_reg_num, input, COLLECTOR_SIZE*SLOT_NUM*REG_ADDR_W, register number per operand
- rsp_valid, output, 1, response valid
- rsp_ready, input, 1, collector accepts response
- rsp_data_valid, output, BANK_NUM, per-bank read returned
- rsp_collector_index, output, BANK_NUM*2, target entry per bank
- rsp_reg_index, output, BANK_NUM*2, operand slot (1..3) per bank
- rsp_data, output, BANK_NUM*DATA_W, read data per bank
- wb_valid, input, 1, writeback request
- wb_reg, input, REG_ADDR_W, writeback register
- wb_data, input, DATA_W, writeback data

Behaviour:
- Reset: state IDLE; req_ready=1; rsp_valid=0; all rsp_* vectors 0. Register contents zeroed.
- All transitions are gated by rdy; when rdy=0, state, outputs and storage hold and writeback is not performed.
- IDLE: on req_valid && req_ready, latch the whole batch, go to ARB. req_ready drops the next cycle.
- Request qualification: an operand is pending iff req_entry_valid[e] && req_reg_valid[e][s] && s!=0.
- ARB (1 cycle):
  - Per bank, grant the lowest (e*SLOT_NUM+s) pending operand mapping to that bank.
  - Banks with no pending operand are idle.
  - Issue synchronous reads; go to READ.
- Writeback conflict:
  - Any cycle wb_valid=1 writes wb_data to wb_reg.
  - If in ARB and the write targets bank b, bank b's read is not granted this batch (rsp_data_valid[b]=0). The write always wins.
- Register 0 reads as 0; writes to reg 0 are ignored.
- READ: bank data returns one cycle after the read; register outputs; go to RESP with rsp_valid=1.
- RESP:
  - Hold all rsp_* stable until rsp_valid && rsp_ready, then clear rsp_valid and go to IDLE.
  - req_ready rises in the same cycle rsp_valid clears.
- Latency: request accept → rsp_valid = 3 cycles when rsp_ready is held high.
- Empty batch (no pending operands): still produces a response with rsp_data_valid all 0.
- Writeback to a row read in the same ARB cycle on another bank is unaffected. The read returns pre-write data only if it targets the same bank, and in that case the read is suppressed per the conflict rule.
- Reset mid-operation: abort immediately to IDLE; any in-flight response is discarded.

Test Plan:
- Reset, then write reg 9 = 0xDEADBEEF via wb. Request entry 0 with rs1=9 → 3 cycles later rsp_valid=1, rsp_data_valid[1]=1, rsp_reg_index[1]=1, rsp_collector_index[1]=0, rsp_data[1]=0xDEADBEEF.
- Bank conflict: entry 0 rs1=4, entry 1 rs2=8 (both bank 0) → only entry 0 slot 1 served on bank 0. A resubmitted batch with only entry 1 rs2=8 then serves it.
- Full spread: entries 0..3 with rs1 = 1, 2, 3, 5 (banks 1, 2, 3, 1) → banks 1/2/3 valid, serving entries 0/1/2; entry 3 dropped; bank 0 invalid.
- Writeback conflict: wb_valid to reg 6 during ARB while a read of reg 2 is pending (bank 2) → rsp_data_valid[2]=0. A follow-up batch reading reg 6 returns the new value.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_* stable and req_ready=0 throughout. Release → handshake completes, IDLE next cycle.
- Assert rst during READ → rsp_valid=0, req_ready=1 immediately. A new request completes normally.
